add_arbiter: RTL
================

Name: add_arbiter

Overview:
- Shares one 32-bit `add` datapath between NUM_REQ requesters, e.g. PC+4, branch target, load/store address generation and ALU.
- Round-robin arbitration with a valid/ready handshake on every request port.
- One registered result port with backpressure, tagged with the requester ID.
- Sits between the decode/execute request sources and the single shared adder instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand/result width.
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_data1  input  NUM_REQ*WIDTH  flattened operand A; requester i at bits [i*WIDTH +: WIDTH].
- req_data2  input  NUM_REQ*WIDTH  flattened operand B, same packing.
- rsp_valid  output  1  result register holds a valid sum.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  ID_W  index of the requester that owns rsp_result.
- rsp_result  output  WIDTH  registered sum.
- busy  output  1  rsp_valid OR any req_valid.

Behaviour:
Reset (rst_n low at a rising clk):
- rsp_valid=0, rsp_id=0, rsp_result=0, rr_ptr=0.
- req_ready=0 while rst_n is low. Requests presented during reset are not accepted.
- Reset mid-operation discards any held result; nothing is replayed.

Slot and ready:
- slot_free = !rsp_valid || rsp_ready.
- req_ready[i]=1 only when slot_free=1 and i is the winning index. req_ready is combinational from req_valid, rr_ptr and rsp state.

Arbitration:
- Round-robin search starts at rr_ptr and runs rr_ptr, rr_ptr+1, … mod NUM_REQ.
- The first index with req_valid set wins.
- On handshake by requester g, rr_ptr <= (g+1) mod NUM_REQ.
- rr_ptr holds when there is no handshake.

Datapath:
- Winner's data1/data2 are muxed into the single adder.
- Sum = (data1 + data2) mod 2^WIDTH. Carry is discarded, e.g. 3 + 0xFFFFFFFF = 2.
- No signedness distinction.

Latency and throughput:
- Handshake at edge N gives rsp_valid=1, rsp_result and rsp_id at edge N.
- This means visible in the cycle after the request cycle: 1-cycle latency.
- Back-to-back throughput is 1 result/cycle while rsp_ready stays high.

Backpressure:
- While rsp_valid && !rsp_ready, rsp_result and rsp_id hold stable and all req_ready=0.

Simultaneous consume and accept:
- rsp_ready=1 and a new handshake in the same cycle: the register loads the new result and rsp_valid stays 1.

Response without new request:
- rsp_ready=1 with no handshake: rsp_valid <= 0. rsp_result and rsp_id keep their last values.

Requester protocol:
- A requester must hold req_valid and its data until req_ready.
- Deasserting req_valid before acceptance is legal; that request is simply dropped.

No requests:
- All req_valid=0: req_ready=0 and no state change beyond the response drain.

Optional Feature:
- Macro ADD_ARBITER_FLAGS_EN.
- Defined: adds outputs rsp_carry (1) and rsp_ovf (1), registered alongside rsp_result.
  - rsp_carry = unsigned carry-out of bit WIDTH-1.
  - rsp_ovf = signed overflow: operand signs equal and sum sign differs.
  - Reset value 0 for both.
  - Example: 3 + 0xFFFFFFFF gives carry=1, ovf=0. 0x7FFFFFFF + 1 gives carry=0, ovf=1.
- Undefined: ports and logic absent; adder carry is unused.

Decomposition:
- Package add_arb_pkg holds:
  - constants ADD_W=32, ARB_MAX_REQ=8;
  - the typedef for requester ID;
  - the typedef for the result record {id, result, carry, ovf}.
- Sub-module rr_arbiter (parameter NUM_REQ): inputs req, ptr, en; outputs one-hot grant and encoded grant_id. It is reusable for other shared units.
- The existing `add` module is instantiated once inside add_arbiter.

Test Plan:
1. Reset with all req_valid=1 for 3 cycles → req_ready=0, rsp_valid=0, rsp_result=0 throughout. First grant after release goes to requester 0.
2. Req0 only, data1=1, data2=2, rsp_ready=1 → next cycle rsp_valid=1, rsp_id=0, rsp_result=3. Then req0 with 3 + 0xFFFFFFFF → rsp_result=2.
3. All 4 requesters valid continuously, rsp_ready=1 → grants in order 0,1,2,3,0,1; rsp_id follows with 1-cycle lag; one result per cycle.
4. Req1 and Req2 valid, rsp_ready held 0 for 5 cycles after the first result → rsp_result/rsp_id stable and req_ready=0 for those 5 cycles. Release gives the next grant to req2, the first valid index at or after rr_ptr=2.
5. rst_n pulsed low for 1 cycle while rsp_valid=1 and requests pending → rsp_valid=0 next cycle, rr_ptr=0. The pending request is re-granted only after reset, starting from requester 0.
6. With ADD_ARBITER_FLAGS_EN: 0x7FFFFFFF+1 → rsp_result=0x80000000, rsp_ovf=1, rsp_carry=0. 0xFFFFFFFF+1 → rsp_result=0, rsp_carry=1, rsp_ovf=0.

Source files
------------

// File: rtl/add_arb_pkg.sv
// add_arb_pkg: shared constants and record types for the add_arbiter slice.
package add_arb_pkg;

  localparam int unsigned ADD_W       = 32;
  localparam int unsigned ARB_MAX_REQ = 8;

  // Wide enough to name any requester up to ARB_MAX_REQ.
  typedef logic [$clog2(ARB_MAX_REQ)-1:0] req_id_t;

  typedef struct packed {
    req_id_t          id;
    logic [ADD_W-1:0] result;
    logic             carry;
    logic             ovf;
  } add_rsp_t;

endpackage

// File: rtl/add.sv
// add: plain unsigned adder with carry-out, shared by the arbiter.
module add #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin picker; search starts at ptr and wraps modulo NUM_REQ.
// grant is one-hot (gated by en); grant_id is the winning index whenever any req is set.
module rr_arbiter
  import add_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  req_id_t            ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output req_id_t            grant_id
);

  // First set request at or after ptr wins.
  always_comb begin : search
    int unsigned idx;
    logic        found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant_id   = req_id_t'(idx);
        grant[idx] = en;
      end
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// add_arbiter: shares one adder between NUM_REQ valid/ready requesters with a
// single registered, backpressured result port tagged with the requester ID.
// Optional macro ADD_ARBITER_FLAGS_EN adds registered rsp_carry / rsp_ovf outputs.
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_data1,
  input  logic [NUM_REQ*WIDTH-1:0] req_data2,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
`ifdef ADD_ARBITER_FLAGS_EN
  output logic                     rsp_carry,
  output logic                     rsp_ovf,
`endif
  output logic                     busy
);

  req_id_t            rr_ptr;
  req_id_t            grant_id;
  logic [NUM_REQ-1:0] grant;
  logic               slot_free;
  logic               arb_en;
  logic               hs;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  add_rsp_t           rsp_d;
  add_rsp_t           rsp_q;
  logic               unused_ok;

  assign slot_free = !rsp_valid || rsp_ready;
  // Holding off grants while rst_n is low keeps requests from being accepted in reset.
  assign arb_en    = slot_free && rst_n;
  assign req_ready = grant;
  assign hs        = |grant;
  assign busy      = rsp_valid || (|req_valid);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .en       (arb_en),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Route the winner's operands into the shared adder.
  always_comb begin
    op_a = req_data1[32'(grant_id)*WIDTH +: WIDTH];
    op_b = req_data2[32'(grant_id)*WIDTH +: WIDTH];
  end

  add #(.WIDTH(WIDTH)) u_add (
    .a     (op_a),
    .b     (op_b),
    .sum   (sum),
    .carry (carry)
  );

  // Assemble the record loaded into the result register on a handshake.
  always_comb begin
    rsp_d        = '0;
    rsp_d.id     = grant_id;
    rsp_d.result = ADD_W'(sum);
`ifdef ADD_ARBITER_FLAGS_EN
    rsp_d.carry  = carry;
    rsp_d.ovf    = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
`endif
  end

  // Result register and round-robin pointer; load on handshake, drain on consume.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
      rr_ptr    <= '0;
    end else if (hs) begin
      rsp_valid <= 1'b1;
      rsp_q     <= rsp_d;
      rr_ptr    <= req_id_t'((32'(grant_id) + 32'd1) % NUM_REQ);
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign rsp_id     = rsp_q.id[ID_W-1:0];
  assign rsp_result = rsp_q.result[WIDTH-1:0];
`ifdef ADD_ARBITER_FLAGS_EN
  assign rsp_carry  = rsp_q.carry;
  assign rsp_ovf    = rsp_q.ovf;
`endif

  // Bits of the shared record/adder not surfaced in every configuration.
  assign unused_ok = &{1'b0, rsp_q, carry};

endmodule
